axil_master_bridge: RTL

- Converts the core's OBI-style data request interface (req/gnt/rvalid, as driven by cv32e40p LSU) into an AXI4-Lite master port.
- The AXI port carries the same signal subset the peripheral wrapper consumes: AW/W/B/AR/R with no resp and no prot.
- Sits between the core data port and the data-side address decoder.
- Owns single-outstanding sequencing and a bus timeout, so accesses to unmapped or hung slaves (e.g. 0x1000_5xxx–0x1000_7xxx) return an error instead of stalling the core.

---
 rtl/soc_bus_pkg.sv | 23 ++
 rtl/bus_timeout_ctr.sv | 31 +++
 rtl/axil_master_bridge.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: bridge FSM states, default bus timeout and
// the peripheral address map fields used by the decoders.
package soc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } bridge_state_t;

    localparam int          DEFAULT_TIMEOUT_CYCLES = 256;
    localparam logic [31:0] PERIPH_BASE            = 32'h1000_0000;
    localparam int          SLOT_MSB               = 14;
    localparam int          SLOT_LSB               = 12;

    function automatic logic [SLOT_MSB-SLOT_LSB:0] slot_sel(input logic [31:0] addr);
        return addr[SLOT_MSB:SLOT_LSB];
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Wait-state cycle counter. expired flags the cycle in which the number of
// enabled cycles since clear reaches LIMIT; LIMIT = 0 never expires.
module bus_timeout_ctr #(
    parameter int LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [W-1:0] cnt_reg;

    // The count stops one short of the limit, so expired stays asserted in
    // every later enabled cycle until a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable && !expired) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign expired = (LIMIT > 0) && enable && ((32'(cnt_reg) + 32'd1) == 32'(LIMIT));

endmodule

// File: rtl/axil_master_bridge.sv
// Core OBI-style data request to AXI4-Lite master bridge with one outstanding
// access and a wait-state timeout that turns hung slaves into error responses.
module axil_master_bridge
    import soc_bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    output logic        core_gnt,
    input  logic [31:0] core_addr,
    input  logic        core_we,
    input  logic [3:0]  core_be,
    input  logic [31:0] core_wdata,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        core_err,
    output logic [31:0] m_awaddr,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    output logic        m_rready
);

    bridge_state_t state_reg, state_next;
    logic          aw_done_reg, aw_done_next;
    logic          w_done_reg, w_done_next;
    logic [31:0]   addr_reg, wdata_reg;
    logic [3:0]    be_reg;
    logic [31:0]   rdata_reg, rdata_next;
    logic          err_reg, err_next;
    logic          aw_hs, w_hs;
    logic          tmo_en, tmo_expired;

    assign core_gnt  = core_req & (state_reg == ST_IDLE);
    assign m_awvalid = (state_reg == ST_WR) & ~aw_done_reg;
    assign m_wvalid  = (state_reg == ST_WR) & ~w_done_reg;
    assign m_bready  = (state_reg == ST_WR_RESP);
    assign m_arvalid = (state_reg == ST_RD_ADDR);
    assign m_rready  = (state_reg == ST_RD_DATA);
    assign m_awaddr  = addr_reg;
    assign m_araddr  = addr_reg;
    assign m_wdata   = wdata_reg;
    assign m_wstrb   = be_reg;

    assign core_rvalid = (state_reg == ST_RESP);
    assign core_rdata  = rdata_reg;
    assign core_err    = err_reg;

    assign aw_hs  = m_awvalid & m_awready;
    assign w_hs   = m_wvalid & m_wready;
    assign tmo_en = state_reg inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};

    bus_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (core_gnt),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            rdata_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            rdata_reg   <= rdata_next;
            err_reg     <= err_next;
            if (core_gnt) begin
                addr_reg  <= core_addr;
                wdata_reg <= core_wdata;
                be_reg    <= core_be;
            end
        end
    end

    // A handshake in the expiry cycle takes priority over the abort.
    always_comb begin
        state_next   = state_reg;
        rdata_next   = rdata_reg;
        err_next     = err_reg;
        aw_done_next = (state_reg == ST_WR) & (aw_done_reg | aw_hs);
        w_done_next  = (state_reg == ST_WR) & (w_done_reg | w_hs);
        unique case (state_reg)
            ST_IDLE: begin
                if (core_gnt) begin
                    state_next = core_we ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                if (aw_done_next && w_done_next) begin
                    state_next = ST_WR_RESP;
                end else if (tmo_expired) begin
                    state_next = ST_RESP;
                    rdata_next = '0;
                    err_next   = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    state_next = ST_RESP;
                    rdata_next = '0;
                    err_next   = 1'b0;
                end else if (tmo_expired) begin
                    state_next = ST_RESP;
                    rdata_next = '0;
                    err_next   = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    state_next = ST_RD_DATA;
                end else if (tmo_expired) begin
                    state_next = ST_RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    state_next = ST_RESP;
                    rdata_next = m_rdata;
                    err_next   = 1'b0;
                end else if (tmo_expired) begin
                    state_next = ST_RESP;
                    rdata_next = ERR_RDATA;
                    err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
